// File: rtl/fdtd_mem_word_rd.sv
// fdtd_mem_word_rd: AXI4 single-beat read master turning a req/gnt word read into one AR/R transfer.
module fdtd_mem_word_rd #(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  output logic [AXI4_ID_WIDTH-1:0]     ARID_o,
  output logic [AXI4_ADDR_WIDTH-1:0]   ARADDR_o,
  output logic [7:0]                   ARLEN_o,
  output logic [2:0]                   ARSIZE_o,
  output logic [1:0]                   ARBURST_o,
  output logic                         ARLOCK_o,
  output logic [3:0]                   ARCACHE_o,
  output logic [2:0]                   ARPROT_o,
  output logic [3:0]                   ARREGION_o,
  output logic [3:0]                   ARQOS_o,
  output logic [AXI4_USER_WIDTH-1:0]   ARUSER_o,
  output logic                         ARVALID_o,
  input  logic                         ARREADY_i,
  input  logic [AXI4_ID_WIDTH-1:0]     RID_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   RDATA_i,
  input  logic [1:0]                   RRESP_i,
  input  logic                         RLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]   RUSER_i,
  input  logic                         RVALID_i,
  output logic                         RREADY_o,
  input  logic                         rd_req_i,
  input  logic [AXI4_ADDR_WIDTH-3:0]   rd_word_addr_i,
  output logic [AXI4_DATA_WIDTH-1:0]   rd_data_o,
  output logic                         rd_err_o,
  output logic                         rd_gnt_o
);
  localparam logic [1:0] RS_IDLE         = 2'd0;
  localparam logic [1:0] RS_WAIT_ARREADY = 2'd1;
  localparam logic [1:0] RS_WAIT_RVALID  = 2'd2;
  localparam logic [1:0] RS_GNT          = 2'd3;
  logic [1:0] state;
  logic unused_ok;
  assign unused_ok  = ^{RID_i, RUSER_i};
  assign ARID_o     = '0;
  assign ARADDR_o   = {rd_word_addr_i, 2'b00};
  assign ARLEN_o    = 8'd0;
  assign ARSIZE_o   = 3'd2;
  assign ARBURST_o  = 2'b01;
  assign ARLOCK_o   = 1'b0;
  assign ARCACHE_o  = 4'd0;
  assign ARPROT_o   = 3'd0;
  assign ARREGION_o = 4'd0;
  assign ARQOS_o    = 4'd0;
  assign ARUSER_o   = '0;
  // ARVALID follows the request combinationally in idle, so it is gated while reset is held
  assign ARVALID_o  = ~ARESET & ((state == RS_IDLE & rd_req_i) | state == RS_WAIT_ARREADY);
  assign RREADY_o   = state == RS_WAIT_RVALID;
  assign rd_gnt_o   = state == RS_GNT;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= RS_IDLE;
      rd_data_o <= '0;
      rd_err_o  <= 1'b0;
    end else begin
      case (state)
        RS_IDLE:         state <= rd_req_i ? (ARREADY_i ? RS_WAIT_RVALID : RS_WAIT_ARREADY) : RS_IDLE;
        RS_WAIT_ARREADY: state <= ARREADY_i ? RS_WAIT_RVALID : RS_WAIT_ARREADY;
        RS_WAIT_RVALID: if (RVALID_i) begin
          rd_data_o <= RDATA_i;
          rd_err_o  <= RRESP_i[1] | ~RLAST_i;
          state     <= RS_GNT;
        end
        default:         state <= RS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fdtd_mem_word_rd.sv
// tb_fdtd_mem_word_rd: directed self-checking bench for the AXI4 single-beat read master.
module tb_fdtd_mem_word_rd;
  logic        ACLK, ARESET;
  logic [15:0] ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST, RRESP;
  logic        ARLOCK, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [3:0]  ARCACHE, ARREGION, ARQOS;
  logic [9:0]  ARUSER, RUSER;
  logic [15:0] RID;
  logic [31:0] RDATA, rd_data;
  logic        rd_req, rd_err, rd_gnt;
  logic [29:0] rd_word_addr;
  int n_assert = 0, n_fail = 0, ar_cnt = 0, gnt_cnt = 0;

  fdtd_mem_word_rd dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_o(ARID), .ARADDR_o(ARADDR), .ARLEN_o(ARLEN), .ARSIZE_o(ARSIZE),
    .ARBURST_o(ARBURST), .ARLOCK_o(ARLOCK), .ARCACHE_o(ARCACHE), .ARPROT_o(ARPROT),
    .ARREGION_o(ARREGION), .ARQOS_o(ARQOS), .ARUSER_o(ARUSER),
    .ARVALID_o(ARVALID), .ARREADY_i(ARREADY),
    .RID_i(RID), .RDATA_i(RDATA), .RRESP_i(RRESP), .RLAST_i(RLAST), .RUSER_i(RUSER),
    .RVALID_i(RVALID), .RREADY_o(RREADY),
    .rd_req_i(rd_req), .rd_word_addr_i(rd_word_addr),
    .rd_data_o(rd_data), .rd_err_o(rd_err), .rd_gnt_o(rd_gnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (ARVALID && ARREADY) ar_cnt <= ar_cnt + 1;
    if (rd_gnt) gnt_cnt <= gnt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full read: arw cycles of ARREADY low, rw cycles of RVALID low, then gnt checks.
  task automatic rd(input logic [29:0] a, input logic [31:0] exp_addr, input int arw, input int rw,
                    input logic [31:0] d, input logic [1:0] resp, input logic last, input logic exp_err);
    rd_req = 1; rd_word_addr = a; ARREADY = (arw == 0); RVALID = 0;
    #1;
    chk("idle_arvalid", ARVALID, 1);
    chk("araddr", ARADDR, exp_addr);
    chk("idle_rready", RREADY, 0);
    for (int i = 1; i <= arw; i++) begin
      @(posedge ACLK); #1;
      rd_req = 0; ARREADY = (i == arw); RVALID = 1; RDATA = 32'hBAD0BAD0;
      #1;
      chk("wait_ar_arvalid", ARVALID, 1);
      chk("wait_ar_rready", RREADY, 0);
    end
    for (int j = 0; j <= rw; j++) begin
      @(posedge ACLK); #1;
      rd_req = (arw == 0); ARREADY = 0;
      RVALID = (j == rw); RDATA = (j == rw) ? d : 32'h0BAD0BAD; RRESP = resp; RLAST = last;
      #1;
      chk("wait_r_rready", RREADY, 1);
      chk("wait_r_arvalid", ARVALID, 0);
      chk("wait_r_gnt", rd_gnt, 0);
    end
    @(posedge ACLK); #1;
    rd_req = 0; RVALID = 0; RRESP = 0; RLAST = 1;
    #1;
    chk("gnt_pulse", rd_gnt, 1);
    chk("gnt_data", rd_data, d);
    chk("gnt_err", rd_err, exp_err);
    chk("gnt_rready", RREADY, 0);
    @(posedge ACLK); #1;
    RVALID = 1;
    #1;
    chk("post_gnt", rd_gnt, 0);
    chk("post_data_held", rd_data, d);
    chk("post_rready", RREADY, 0);
    RVALID = 0;
  endtask

  initial begin
    int ar0, g0;
    ARESET = 1;
    rd_req = 1'($urandom); rd_word_addr = 30'($urandom); ARREADY = 1'($urandom);
    RVALID = 1'($urandom); RDATA = $urandom; RRESP = 2'($urandom); RLAST = 1'($urandom);
    RID = 16'($urandom); RUSER = 10'($urandom);
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_gnt", rd_gnt, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_err", rd_err, 0);
    rd_req = 0; ARREADY = 0; RVALID = 0; RRESP = 0; RLAST = 1;
    chk("const_arlen", ARLEN, 0);
    chk("const_arsize", ARSIZE, 2);
    chk("const_arburst", ARBURST, 1);
    chk("const_misc", {ARID, ARLOCK, ARCACHE, ARPROT, ARREGION, ARQOS, ARUSER}, 0);
    ARESET = 0;
    @(posedge ACLK); #1;
    // zero-wait read
    rd(30'h0000_0400, 32'h0000_1000, 0, 0, 32'hDEADBEEF, 2'b00, 1, 0);
    // backpressure on AR and R
    ar0 = ar_cnt; g0 = gnt_cnt;
    rd(30'h0000_0123, 32'h0000_048C, 3, 5, 32'hCAFEF00D, 2'b00, 1, 0);
    chk("bp_ar_count", ar_cnt - ar0, 1);
    chk("bp_gnt_count", gnt_cnt - g0, 1);
    // error responses
    rd(30'h0000_0020, 32'h0000_0080, 0, 1, 32'h12345678, 2'b10, 1, 1);
    rd(30'h0000_0021, 32'h0000_0084, 1, 0, 32'h87654321, 2'b00, 1, 0);
    rd(30'h0000_0022, 32'h0000_0088, 0, 0, 32'h0F0F0F0F, 2'b00, 0, 1);
    rd(30'h0000_0023, 32'h0000_008C, 0, 0, 32'hA5A5A5A5, 2'b01, 1, 0);
    rd(30'h0000_0024, 32'h0000_0090, 0, 0, 32'h5A5A5A5A, 2'b11, 1, 1);
    // back-to-back
    ar0 = ar_cnt; g0 = gnt_cnt;
    rd(30'h0000_0010, 32'h0000_0040, 0, 0, 32'h11111111, 2'b00, 1, 0);
    rd(30'h0000_0011, 32'h0000_0044, 0, 0, 32'h22222222, 2'b00, 1, 0);
    chk("b2b_ar_count", ar_cnt - ar0, 2);
    chk("b2b_gnt_count", gnt_cnt - g0, 2);
    // reset in RS_WAIT_RVALID
    g0 = gnt_cnt;
    rd_req = 1; rd_word_addr = 30'h0000_0055; ARREADY = 1;
    @(posedge ACLK); #1;
    rd_req = 0; ARREADY = 0;
    #1;
    chk("mid_rready_before", RREADY, 1);
    ARESET = 1;
    #1;
    chk("mid_rready", RREADY, 0);
    chk("mid_gnt", rd_gnt, 0);
    chk("mid_data", rd_data, 0);
    chk("mid_err", rd_err, 0);
    @(posedge ACLK); #1;
    ARESET = 0; RVALID = 1; RDATA = 32'h77777777;
    #1;
    chk("mid_idle_rready", RREADY, 0);
    chk("mid_idle_arvalid", ARVALID, 0);
    @(posedge ACLK); #1;
    chk("mid_no_gnt", rd_gnt, 0);
    chk("mid_no_capture", rd_data, 0);
    @(posedge ACLK); #1;
    RVALID = 0;
    chk("mid_gnt_count", gnt_cnt - g0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
